branch_pc_core: RTL and testbench



---
 rtl/branch_pc_core.sv | 97 +++++++++
 tb/tb_branch_pc_core.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/branch_pc_core.sv
// branch_pc_core: 8-bit ALU, branch-target ROM and program counter.
// Optional macro RELJUMP_EN adds rel_en for PC-relative jumps.
module branch_pc_core #(
  parameter int D      = 10,
  parameter int LUT_AW = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   alu_cmd,
  input  logic [7:0]   inA,
  input  logic [7:0]   inB,
  input  logic [7:0]   inC,
  input  logic         branch,
`ifdef RELJUMP_EN
  input  logic         rel_en,
`endif
  output logic [7:0]   rslt,
  output logic         branch_pc,
  output logic [D-1:0] target,
  output logic [D-1:0] prog_ctr
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_BNE = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  logic [LUT_AW-1:0] lut_idx;
  logic              jump;
  logic [D-1:0]      pc_inc;
  logic [D-1:0]      pc_jmp;
  logic [D-1:0]      pc_next;

  // ALU: result and raw branch condition
  always_comb begin
    rslt      = 8'h00;
    branch_pc = 1'b0;
    case (alu_cmd)
      OP_ADD: rslt = inA + inB;
      OP_SUB: rslt = inA - inB;
      OP_AND: rslt = inA & inB;
      OP_BNE: begin
        rslt      = inC;
        branch_pc = (inA != inB);
      end
      OP_OR:  rslt = inA | inB;
      OP_XOR: rslt = inA ^ inB;
      OP_SHL: rslt = inA << inC[2:0];
      OP_SHR: rslt = inA >> inC[2:0];
      default: rslt = 8'h00;
    endcase
  end

  assign lut_idx = rslt[LUT_AW-1:0];

  // Branch-target ROM; unlisted indices point at 0
  always_comb begin
    target = '0;
    case (lut_idx)
      LUT_AW'(0): target = D'(16);
      LUT_AW'(1): target = D'(48);
      LUT_AW'(2): target = D'(128);
      LUT_AW'(3): target = D'(256);
      LUT_AW'(4): target = D'(1023);
      default:    target = '0;
    endcase
  end

  assign jump   = branch & branch_pc;
  assign pc_inc = prog_ctr + D'(1);

`ifdef RELJUMP_EN
  // Relative jumps add the two's-complement target modulo 2^D
  always_comb begin
    pc_jmp = target;
    if (rel_en)
      pc_jmp = prog_ctr + target;
  end
`else
  assign pc_jmp = target;
`endif

  assign pc_next = jump ? pc_jmp : pc_inc;

  // PC register: reset wins over any jump
  always_ff @(posedge clk) begin
    if (reset)
      prog_ctr <= '0;
    else
      prog_ctr <= pc_next;
  end

endmodule

// File: tb/tb_branch_pc_core.sv
// tb_branch_pc_core: scoreboard bench for branch_pc_core.
// Stimulus queues expectations; a negedge monitor pops and compares.
module tb_branch_pc_core;

  logic       clk;
  logic       reset;
  logic [2:0] alu_cmd;
  logic [7:0] inA, inB, inC;
  logic       branch;
  logic [7:0] rslt;
  logic       branch_pc;
  logic [9:0] target;
  logic [9:0] prog_ctr;

  typedef struct {
    string      name;
    logic [7:0] rslt;
    logic       bpc;
    logic [9:0] tgt;
    logic [9:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_pass;
  int   n_total;

  branch_pc_core #(.D(10), .LUT_AW(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .alu_cmd  (alu_cmd),
    .inA      (inA),
    .inB      (inB),
    .inC      (inC),
    .branch   (branch),
`ifdef RELJUMP_EN
    .rel_en   (1'b0),
`endif
    .rslt     (rslt),
    .branch_pc(branch_pc),
    .target   (target),
    .prog_ctr (prog_ctr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld,
                     input logic [9:0] act, input logic [9:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s actual=%0d required=%0d",
                  nm, fld, act, exp);
  endtask

  // Monitor: one sample per queued expectation, mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.name, "rslt", {2'b00, rslt}, {2'b00, e.rslt});
        chk(e.name, "bpc", {9'd0, branch_pc}, {9'd0, e.bpc});
        chk(e.name, "tgt", target, e.tgt);
        chk(e.name, "pc", prog_ctr, e.pc);
      end
    end
  end

  task automatic step(input string nm, input logic rst,
                      input logic [2:0] cmd, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] c,
                      input logic br, input logic [7:0] er,
                      input logic ebpc, input logic [9:0] et,
                      input logic [9:0] ep);
    exp_t e;
    @(posedge clk);
    #1;
    reset   = rst;
    alu_cmd = cmd;
    inA     = a;
    inB     = b;
    inC     = c;
    branch  = br;
    e.name = nm; e.rslt = er; e.bpc = ebpc;
    e.tgt  = et; e.pc   = ep;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    alu_cmd = 3'b000;
    inA = 8'h00; inB = 8'h00; inC = 8'h00;
    branch = 1'b0;
    //   name      rst cmd     A      B      C      br  rslt  bpc tgt  pc
    step("rst0",   1, 3'b000, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 16,   0);
    step("rst1",   0, 3'b000, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 16,   0);
    step("inc1",   0, 3'b000, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 16,   1);
    step("inc2",   0, 3'b000, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 16,   2);
    step("beq",    0, 3'b011, 8'h03, 8'h03, 8'h00, 1, 8'h00, 0, 16,   3);
    step("bne0",   0, 3'b011, 8'h03, 8'h02, 8'h00, 1, 8'h00, 1, 16,   4);
    step("jmp16",  0, 3'b011, 8'h03, 8'h02, 8'h00, 1, 8'h00, 1, 16,  16);
    step("hold16", 0, 3'b011, 8'h03, 8'h02, 8'h00, 1, 8'h00, 1, 16,  16);
    step("bne1",   0, 3'b011, 8'h03, 8'h02, 8'h01, 1, 8'h01, 1, 48,  16);
    step("nobr",   0, 3'b011, 8'h03, 8'h02, 8'h01, 0, 8'h01, 1, 48,  48);
    step("brnop",  0, 3'b000, 8'h03, 8'h02, 8'h00, 1, 8'h05, 0,  0,  49);
    step("bne4",   0, 3'b011, 8'h01, 8'h00, 8'h04, 1, 8'h04, 1, 1023, 50);
    step("at1023", 0, 3'b000, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 16, 1023);
    step("rstjmp", 1, 3'b011, 8'h01, 8'h00, 8'h02, 1, 8'h02, 1, 128,  0);
    step("rstpc",  0, 3'b011, 8'h01, 8'h00, 8'h02, 1, 8'h02, 1, 128,  0);
    step("jmp128", 0, 3'b011, 8'h01, 8'h00, 8'h03, 1, 8'h03, 1, 256, 128);
    step("add",    0, 3'b000, 8'hF0, 8'h20, 8'h04, 0, 8'h10, 0, 16, 256);
    step("sub",    0, 3'b001, 8'hF0, 8'h20, 8'h04, 0, 8'hD0, 0, 16, 257);
    step("and",    0, 3'b010, 8'hF0, 8'h20, 8'h04, 0, 8'h20, 0, 16, 258);
    step("or",     0, 3'b100, 8'hF0, 8'h20, 8'h04, 0, 8'hF0, 0, 16, 259);
    step("xor",    0, 3'b101, 8'hF0, 8'h20, 8'h04, 0, 8'hD0, 0, 16, 260);
    step("shl",    0, 3'b110, 8'hF0, 8'h20, 8'h04, 0, 8'h00, 0, 16, 261);
    step("shr",    0, 3'b111, 8'hF0, 8'h20, 8'h04, 0, 8'h0F, 0,  0, 262);
    step("idle",   0, 3'b000, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 16, 263);
    step("hiidx",  0, 3'b011, 8'h01, 8'h00, 8'h13, 1, 8'h13, 1, 256, 264);
    step("jmp256", 0, 3'b011, 8'h01, 8'h00, 8'h13, 1, 8'h13, 1, 256, 256);
    step("self",   0, 3'b011, 8'h01, 8'h00, 8'h13, 1, 8'h13, 1, 256, 256);
    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain actual=%0d required=0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
